// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron prediction slice.
// Holds the geometry (ways, history length, weight and sum widths), the
// training threshold, the pending-queue entry layout and the train FSM states.
package perceptron_pkg;

  localparam int NWAY   = 4;   // parallel lookups per cycle
  localparam int NHIST  = 8;   // history bits per perceptron; bias sits at index NHIST
  localparam int WBITS  = 8;   // signed weight width
  localparam int SUMW   = 12;  // dot-product width; |sum| <= 9*128 = 1152 fits
  localparam int THETA  = 29;  // floor(1.93*NHIST + 14)
  localparam int QDEPTH = 4;   // pending-queue depth, power of two
  localparam int ABITS  = 8;   // per-way table index width
  localparam int TGHR_W = 20;  // training outcome/history word width

  typedef logic signed [SUMW-1:0] sum_t;

  // One outstanding lookup, kept until its branch resolves.
  typedef struct packed {
    logic [NWAY*ABITS-1:0] addrs;
    logic [NHIST-1:0]      ghr;
    logic [NWAY*SUMW-1:0]  sums;
  } q_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } train_state_t;

endpackage

// File: rtl/perceptron_predict_if.sv
// Bus bundle between the weight table / resolve logic and perceptron_predict.
// master: the side that supplies lookups, resolves and train acknowledgements.
// slave : perceptron_predict itself.
//   lookup  : i_valid, o_ready, i_weights_288, i_addrs_32, i_ghr
//   predict : o_pred_valid, o_taken
//   resolve : i_resolve_valid, i_resolve_way, i_resolve_taken, o_resolve_ready
//   train   : o_train_valid, i_train_ready, o_errPos, o_trainGhr_20
interface perceptron_predict_if;
  import perceptron_pkg::*;

  logic                            i_valid;
  logic                            o_ready;
  logic [NWAY*(NHIST+1)*WBITS-1:0] i_weights_288;
  logic [NWAY*ABITS-1:0]           i_addrs_32;
  logic [NHIST-1:0]                i_ghr;
  logic                            o_pred_valid;
  logic [NWAY-1:0]                 o_taken;
  logic                            i_resolve_valid;
  logic [1:0]                      i_resolve_way;
  logic                            i_resolve_taken;
  logic                            o_resolve_ready;
  logic                            o_train_valid;
  logic                            i_train_ready;
  logic [ABITS-1:0]                o_errPos;
  logic [TGHR_W-1:0]               o_trainGhr_20;

  modport master (
    output i_valid, i_weights_288, i_addrs_32, i_ghr,
    output i_resolve_valid, i_resolve_way, i_resolve_taken, i_train_ready,
    input  o_ready, o_pred_valid, o_taken, o_resolve_ready,
    input  o_train_valid, o_errPos, o_trainGhr_20
  );

  modport slave (
    input  i_valid, i_weights_288, i_addrs_32, i_ghr,
    input  i_resolve_valid, i_resolve_way, i_resolve_taken, i_train_ready,
    output o_ready, o_pred_valid, o_taken, o_resolve_ready,
    output o_train_valid, o_errPos, o_trainGhr_20
  );

endinterface

// File: rtl/perceptron_sum.sv
// One way's perceptron dot product, two register stages deep.
// Ports:
//   clk     in   rising-edge clock (datapath only, no reset)
//   weights in   NHIST+1 weights, weight k at [k*WBITS +: WBITS], bias last
//   ghr     in   history; bit k = 1 keeps weight k, 0 negates it
//   sum_p2  out  signed sum, valid two cycles after the inputs
module perceptron_sum
  import perceptron_pkg::*;
(
  input  logic                       clk,
  input  logic [(NHIST+1)*WBITS-1:0] weights,
  input  logic [NHIST-1:0]           ghr,
  output sum_t                       sum_p2
);

  sum_t term_d  [NHIST+1];
  sum_t term_p1 [NHIST+1];
  sum_t acc;

  // Widening first means negating -128 yields +128 rather than wrapping.
  function automatic sum_t ext_weight(input logic signed [WBITS-1:0] w);
    return sum_t'(w);
  endfunction

  always_comb begin
    for (int k = 0; k < NHIST; k++) begin
      term_d[k] = ext_weight(weights[k*WBITS +: WBITS]);
      if (!ghr[k]) term_d[k] = -term_d[k];
    end
    term_d[NHIST] = ext_weight(weights[NHIST*WBITS +: WBITS]);
  end

  // ---- stage 1: signed, history-adjusted terms ----
  always_ff @(posedge clk) term_p1 <= term_d;

  // Nine terms of at most 128 each cannot exceed the 12-bit range.
  always_comb begin
    acc = '0;
    for (int k = 0; k <= NHIST; k++) acc = acc + term_p1[k];
  end

  // ---- stage 2: summed dot product ----
  always_ff @(posedge clk) sum_p2 <= acc;

endmodule

// File: rtl/perceptron_predict.sv
// Perceptron predictor: four parallel dot products, taken/not-taken
// predictions, an in-order pending queue and the training-request FSM that
// feeds updates back to the weight table.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   bus  perceptron_predict_if.slave (lookup, predict, resolve, train groups)
// Build option: PERCEPTRON_THETA_TRAIN_EN also trains on correct predictions
// whose |sum| <= THETA; without it only mispredictions train.
module perceptron_predict
  import perceptron_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  perceptron_predict_if.slave bus
);

  localparam int PTRW = $clog2(QDEPTH);
  localparam int WPW  = (NHIST+1)*WBITS;

  logic                  vld_p1, vld_p2;
  logic [NWAY*ABITS-1:0] addrs_p1, addrs_p2;
  logic [NHIST-1:0]      ghr_p1, ghr_p2;
  logic [NWAY*SUMW-1:0]  sums_p2;
  logic [NWAY-1:0]       taken;

  q_entry_t         queue [QDEPTH];
  logic [PTRW-1:0]  rd_ptr, wr_ptr;
  logic [PTRW:0]    count;
  logic [PTRW+1:0]  occupancy;
  logic             accept, push, pop, latch, resolve_ready;

  train_state_t     state, state_nxt;
  q_entry_t         head;
  sum_t             head_sums  [NWAY];
  logic [ABITS-1:0] head_addrs [NWAY];
  sum_t             head_sum;
  logic             mispredict, train_need;
  logic [ABITS-1:0]  err_pos;
  logic [TGHR_W-1:0] train_ghr;

  // In-flight lookups reserve a slot so a push can never find the queue full.
  assign occupancy = (PTRW+2)'(count) + (PTRW+2)'(vld_p1) + (PTRW+2)'(vld_p2);
  assign accept    = bus.i_valid & bus.o_ready;

  for (genvar w = 0; w < NWAY; w++) begin : g_way
    perceptron_sum u_sum (
      .clk     (clk),
      .weights (bus.i_weights_288[w*WPW +: WPW]),
      .ghr     (bus.i_ghr),
      .sum_p2  (sums_p2[w*SUMW +: SUMW])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1 / stage 2: lookup context travelling beside the sums ----
  always_ff @(posedge clk) begin
    addrs_p1 <= bus.i_addrs_32;
    ghr_p1   <= bus.i_ghr;
    addrs_p2 <= addrs_p1;
    ghr_p2   <= ghr_p1;
  end

  // Gated by the valid so o_taken reads 0 out of reset.
  always_comb begin
    for (int w = 0; w < NWAY; w++) taken[w] = vld_p2 & ~sums_p2[w*SUMW + SUMW - 1];
  end

  // ---- pending queue: entries enter from stage 2 ----
  assign push = vld_p2;

  always_ff @(posedge clk) begin
    if (push) queue[wr_ptr] <= '{addrs: addrs_p2, ghr: ghr_p2, sums: sums_p2};
  end

  assign head = queue[rd_ptr];

  always_comb begin
    for (int w = 0; w < NWAY; w++) begin
      head_sums[w]  = sum_t'(head.sums[w*SUMW +: SUMW]);
      head_addrs[w] = head.addrs[w*ABITS +: ABITS];
    end
  end

  assign head_sum   = head_sums[bus.i_resolve_way];
  assign mispredict = (~head_sum[SUMW-1]) != bus.i_resolve_taken;

`ifdef PERCEPTRON_THETA_TRAIN_EN
  function automatic logic [SUMW-1:0] abs_sum(input sum_t s);
    return s[SUMW-1] ? SUMW'(-s) : SUMW'(s);
  endfunction

  assign train_need = mispredict | (abs_sum(head_sum) <= SUMW'(THETA));
`else
  assign train_need = mispredict;
`endif

  always_comb begin
    state_nxt     = state;
    resolve_ready = 1'b0;
    pop           = 1'b0;
    latch         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        resolve_ready = (count != '0);
        if (bus.i_resolve_valid && resolve_ready) begin
          if (train_need) begin
            latch     = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // The head stays queued until the table acknowledges the update.
        if (bus.i_train_ready) begin
          pop       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      err_pos   <= '0;
      train_ghr <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (latch) begin
        err_pos   <= head_addrs[bus.i_resolve_way];
        train_ghr <= {{(TGHR_W-NHIST-1){1'b0}}, head.ghr, bus.i_resolve_taken};
      end
    end
  end

  assign bus.o_ready         = occupancy < (PTRW+2)'(QDEPTH);
  assign bus.o_pred_valid    = vld_p2;
  assign bus.o_taken         = taken;
  assign bus.o_resolve_ready = resolve_ready;
  assign bus.o_train_valid   = (state == ST_REQ);
  assign bus.o_errPos        = err_pos;
  assign bus.o_trainGhr_20   = train_ghr;

endmodule

// File: tb/tb_perceptron_predict.sv
// Self-checking bench for perceptron_predict: directed steps followed by a
// randomized phase, all checked against a transaction-level model (list of
// accepted lookups with integer sums, plus a pending-train flag).
module tb_perceptron_predict;
  import perceptron_pkg::*;

  localparam int WTOT = NWAY*(NHIST+1)*WBITS;
`ifdef PERCEPTRON_THETA_TRAIN_EN
  localparam bit THETA_EN = 1'b1;
`else
  localparam bit THETA_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  perceptron_predict_if bus();

  perceptron_predict dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NWAY*ABITS-1:0] addrs;
    logic [NHIST-1:0]      ghr;
    int                    sums [NWAY];
    int                    acc;
  } rec_t;

  rec_t              pend[$];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  bit                in_req = 1'b0;
  bit                fired = 1'b0;
  logic [ABITS-1:0]  exp_err = '0;
  logic [TGHR_W-1:0] exp_tghr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Dot product straight from the rules: bias plus +/- each weight.
  function automatic int way_sum(input logic [WTOT-1:0] wt, input logic [NHIST-1:0] g, input int w);
    int s;
    logic signed [WBITS-1:0] x;
    x = wt[(w*(NHIST+1)+NHIST)*WBITS +: WBITS];
    s = int'(x);
    for (int k = 0; k < NHIST; k++) begin
      x = wt[(w*(NHIST+1)+k)*WBITS +: WBITS];
      s += g[k] ? int'(x) : -int'(x);
    end
    return s;
  endfunction

  function automatic logic [WTOT-1:0] uniform(input logic [WBITS-1:0] v);
    logic [WTOT-1:0] wt;
    for (int i = 0; i < NWAY*(NHIST+1); i++) wt[i*WBITS +: WBITS] = v;
    return wt;
  endfunction

  function automatic logic [WTOT-1:0] put(input logic [WTOT-1:0] wt, input int w, input int k,
                                          input logic [WBITS-1:0] v);
    wt[(w*(NHIST+1)+k)*WBITS +: WBITS] = v;
    return wt;
  endfunction

  // One clock: check pre-edge outputs, advance the model, then check post-edge outputs.
  task automatic tick();
    bit rr, acc, need, pv;
    int s;
    rec_t r;
    logic [NWAY-1:0] tk;
    fired = 1'b0;
    check("o_ready", bus.o_ready, pend.size() < QDEPTH);
    rr = 1'b0;
    if (!in_req && pend.size() > 0) rr = (pend[0].acc + 3 <= cyc);
    check("o_resolve_ready", bus.o_resolve_ready, rr);
    acc = bus.i_valid && (pend.size() < QDEPTH);
    if (rr && bus.i_resolve_valid) begin
      fired = 1'b1;
      s = pend[0].sums[bus.i_resolve_way];
      need = ((s >= 0) != bus.i_resolve_taken) || (THETA_EN && s <= THETA && s >= -THETA);
      if (need) begin
        in_req   = 1'b1;
        exp_err  = pend[0].addrs[bus.i_resolve_way*ABITS +: ABITS];
        exp_tghr = {{(TGHR_W-NHIST-1){1'b0}}, pend[0].ghr, bus.i_resolve_taken};
      end else begin
        void'(pend.pop_front());
      end
    end else if (in_req && bus.i_train_ready) begin
      in_req = 1'b0;
      void'(pend.pop_front());
    end
    if (acc) begin
      r.addrs = bus.i_addrs_32;
      r.ghr   = bus.i_ghr;
      r.acc   = cyc;
      for (int w = 0; w < NWAY; w++) r.sums[w] = way_sum(bus.i_weights_288, bus.i_ghr, w);
      pend.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    pv = 1'b0;
    tk = '0;
    foreach (pend[i]) begin
      if (pend[i].acc == cyc - 2) begin
        pv = 1'b1;
        for (int w = 0; w < NWAY; w++) tk[w] = (pend[i].sums[w] >= 0);
      end
    end
    check("o_pred_valid", bus.o_pred_valid, pv);
    if (pv) check("o_taken", bus.o_taken, tk);
    check("o_train_valid", bus.o_train_valid, in_req);
    if (in_req) begin
      check("o_errPos", bus.o_errPos, exp_err);
      check("o_trainGhr_20", bus.o_trainGhr_20, exp_tghr);
    end
  endtask

  task automatic set_idle();
    bus.i_valid         = 1'b0;
    bus.i_resolve_valid = 1'b0;
    bus.i_train_ready   = 1'b0;
  endtask

  task automatic lookup(input logic [WTOT-1:0] wt, input logic [NHIST-1:0] g);
    bus.i_weights_288 = wt;
    bus.i_ghr         = g;
    bus.i_addrs_32    = $urandom;
    bus.i_valid       = 1'b1;
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic resolve(input logic [1:0] way, input bit tkn);
    bus.i_resolve_way   = way;
    bus.i_resolve_taken = tkn;
    bus.i_resolve_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (fired) break;
    end
    bus.i_resolve_valid = 1'b0;
    check("resolve_accepted", fired, 1);
  endtask

  task automatic finish_train(input int hold);
    repeat (hold) tick();
    bus.i_train_ready = 1'b1;
    tick();
    bus.i_train_ready = 1'b0;
    check("train_released", bus.o_train_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.o_ready, 1);
    check({tag, "_pred_valid"}, bus.o_pred_valid, 0);
    check({tag, "_taken"}, bus.o_taken, 0);
    check({tag, "_resolve_ready"}, bus.o_resolve_ready, 0);
    check({tag, "_train_valid"}, bus.o_train_valid, 0);
    check({tag, "_errPos"}, bus.o_errPos, 0);
    check({tag, "_trainGhr"}, bus.o_trainGhr_20, 0);
  endtask

  initial begin
    logic [WTOT-1:0]       wt;
    logic [NWAY*ABITS-1:0] saved_addrs;
    logic [1:0]            way;

    set_idle();
    bus.i_weights_288   = '0;
    bus.i_addrs_32      = '0;
    bus.i_ghr           = '0;
    bus.i_resolve_way   = '0;
    bus.i_resolve_taken = 1'b0;

    // Reset
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst_init");
    repeat (2) tick();
    rst = 1'b1;

    // All-zero weights predict taken everywhere; not-taken outcome trains
    lookup(uniform(8'h00), NHIST'($urandom));
    tick();
    check("zero_taken", bus.o_taken, 4'b1111);
    resolve(2'($urandom_range(0, 3)), 1'b0);
    check("zero_train_req", bus.o_train_valid, 1);
    finish_train(5);

    // Way 2 bias -5 predicts not-taken there; taken outcome trains with known word
    wt = put(uniform(8'h00), 2, NHIST, 8'hFB);
    lookup(wt, 8'hFF);
    saved_addrs = bus.i_addrs_32;
    tick();
    check("bias_taken2", bus.o_taken[2], 0);
    resolve(2'd2, 1'b1);
    check("bias_errPos", bus.o_errPos, saved_addrs[2*ABITS +: ABITS]);
    check("bias_trainGhr", bus.o_trainGhr_20, 20'h001FF);
    finish_train(1);

    // Extreme sums: +1143 and +896 both predict taken; correct outcome never trains
    lookup(uniform(8'h7F), 8'hFF);
    lookup(uniform(8'h80), 8'h00);
    check("max_taken", bus.o_taken, 4'b1111);
    tick();
    check("neg128_taken", bus.o_taken, 4'b1111);
    resolve(2'($urandom_range(0, 3)), 1'b1);
    check("max_no_train", bus.o_train_valid, 0);
    resolve(2'($urandom_range(0, 3)), 1'b1);
    check("neg128_no_train", bus.o_train_valid, 0);

    // Small positive sum (+20) predicted correctly: trains only with the threshold option
    wt = uniform(8'h00);
    for (int w = 0; w < NWAY; w++) wt = put(wt, w, NHIST, 8'd20);
    lookup(wt, NHIST'($urandom));
    resolve(2'($urandom_range(0, 3)), 1'b1);
    check("theta_train", bus.o_train_valid, THETA_EN);
    if (in_req) finish_train(0);

    // Four lookups with no resolves fill the queue
    repeat (QDEPTH) lookup(uniform(8'h7F), 8'hFF);
    check("queue_full_ready", bus.o_ready, 0);
    bus.i_valid = 1'b1;
    repeat (3) tick();
    // Streaming lookups and resolves: pushes and pops overlap
    bus.i_resolve_way   = 2'($urandom_range(0, 3));
    bus.i_resolve_taken = 1'b1;
    bus.i_resolve_valid = 1'b1;
    repeat (12) tick();
    set_idle();

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      wt = '0;
      for (int i = 0; i < NWAY*(NHIST+1); i++)
        wt[i*WBITS +: WBITS] = ($urandom_range(0, 1) == 1) ? WBITS'($urandom) : WBITS'($urandom_range(0, 6) - 3);
      bus.i_weights_288   = wt;
      bus.i_addrs_32      = $urandom;
      bus.i_ghr           = NHIST'($urandom);
      bus.i_valid         = 1'($urandom_range(0, 1));
      bus.i_resolve_valid = 1'($urandom_range(0, 1));
      bus.i_resolve_way   = 2'($urandom_range(0, 3));
      bus.i_resolve_taken = 1'($urandom_range(0, 1));
      bus.i_train_ready   = 1'($urandom_range(0, 1));
      tick();
    end
    bus.i_valid         = 1'b0;
    bus.i_resolve_valid = 1'b1;
    bus.i_train_ready   = 1'b1;
    for (int n = 0; n < 80 && pend.size() > 0; n++) begin
      bus.i_resolve_taken = 1'($urandom_range(0, 1));
      tick();
    end
    set_idle();
    tick();
    check("drained_resolve_ready", bus.o_resolve_ready, 0);
    check("drained_ready", bus.o_ready, 1);

    // Reset in the middle of a held training request with lookups pending
    lookup(uniform(8'h00), NHIST'($urandom));
    lookup(uniform(8'h01), NHIST'($urandom));
    resolve(2'd0, 1'b0);
    lookup(uniform(8'h7F), 8'hFF);
    repeat (2) tick();
    check("pre_reset_train_valid", bus.o_train_valid, 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    pend.delete();
    in_req = 1'b0;
    set_idle();
    repeat (2) tick();
    rst = 1'b1;
    lookup(uniform(8'h80), 8'h00);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perceptron_predict.md
# perceptron_predict

Computes the perceptron dot product for four parallel branch lookups from the 288-bit weight vector produced by the weight table, and emits taken/not-taken predictions. It holds each lookup's indices, history and sums in an in-order pending queue until the branch resolves. It then decides whether training is needed and issues the error position plus the 20-bit outcome/history word that the weight table consumes on its update fires. The block sits directly downstream of the weight table and feeds training requests back to it.

## Interface
- NWAY, 4, parallel lookups per cycle
- NHIST, 8, history bits per perceptron (weights per way = NHIST+1, bias at index NHIST)
- WBITS, 8, signed weight width
- THETA, 29, training threshold (floor(1.93*NHIST+14))
- QDEPTH, 4, pending-queue depth (power of two)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- i_valid  in  1  weights/addrs/ghr valid this cycle
- o_ready  out  1  lookup accepted (queue has room, counting in-flight)
- i_weights_288  in  NWAY*(NHIST+1)*WBITS  way w, weight k at bits [(w*(NHIST+1)+k)*WBITS +: WBITS]
- i_addrs_32  in  NWAY*8  per-way table index used for the read
- i_ghr  in  NHIST  speculative history at lookup; bit k pairs with weight k; 1 = taken
- o_pred_valid  out  1  predictions valid
- o_taken  out  NWAY  per-way prediction (sum >= 0)
- i_resolve_valid  in  1  oldest lookup resolved
- i_resolve_way  in  2  which way carried the real branch
- i_resolve_taken  in  1  actual outcome
- o_resolve_ready  out  1  resolve accepted this cycle
- o_train_valid  out  1  training request pending
- i_train_ready  in  1  weight table has completed the update sequence
- o_errPos  out  8  table index to update
- o_trainGhr_20  out  20  bit0 = actual outcome; bits[NHIST:1] = lookup history; rest 0

## Operation
- Stage 1, registered: each weight is sign-extended to 12 bits. Weight k<NHIST is negated when i_ghr[k]=0. The bias is passed through unchanged.
- Stage 2, registered: 9-input signed adder tree per way.
  - Range is ±1152; 12 bits never overflow.
  - Negating -128 gives +128.
- At stage 2, o_pred_valid=1 and o_taken[w]=~sum[w][11]. The queue pushes {addrs, ghr, sums}.
- o_ready = (queue count + in-flight lookups) < QDEPTH.
- Train FSM states:
  - IDLE: o_resolve_ready=1 iff the queue is non-empty. On resolve, select the head entry's way. Set mispredict = (sum>=0) != i_resolve_taken.
    - Training needed: go to REQ, latch o_errPos=addr[way] and o_trainGhr_20.
    - Otherwise: pop the head and stay in IDLE.
  - REQ: o_train_valid=1 and outputs are held stable. When i_train_ready=1, pop the head and go to IDLE.
- A push and a pop in the same cycle are both performed, and the count is unchanged.
- A resolve when the queue is empty is ignored.
- Queue pointers wrap modulo QDEPTH.

## Timing
- Lookup-to-prediction latency: 2 cycles, fully pipelined at 1 lookup per cycle.
- A resolve is accepted in one cycle. o_train_valid rises on the next cycle and stays high until the cycle with i_train_ready, inclusive.
- The earliest next resolve is the cycle after the pop.
- Reset values:
  - All outputs are 0, except o_ready=1.
  - FSM goes to IDLE, the queue is empty, pipeline valids are 0.
- Reset mid-request drops the request and all pending entries.

## Configuration
- PERCEPTRON_THETA_TRAIN_EN defined: training is needed when mispredict OR |sum[way]| <= THETA.
- Undefined: training is needed on mispredict only, and the THETA compare is not built.

## Structure
- Shared package perceptron_pkg holds:
  - NWAY, NHIST, WBITS, the 12-bit sum width, THETA default.
  - The queue entry struct {addrs, ghr, sums}.
  - The train FSM state enum.
- One sub-module, perceptron_sum: one way's negate and adder tree, instantiated NWAY times.

## Test plan
- All weights 0, bias 0: o_taken=4'b1111 two cycles after i_valid. Any resolve_taken=0 produces a training request.
- Way 2 bias=-5, other weights 0, ghr=0xFF: o_taken[2]=0. Resolve way 2 taken=1 → o_errPos=addr[2] and o_trainGhr_20=0x001FF.
- All weights 127 with ghr=0xFF (sum +1143): resolve taken=1 produces no training. Weights -128 with ghr=0x00 (sum +896) also predicts taken.
- With the macro, sum=+20 and correct prediction → training requested. Without the macro → no request.
- Issue 4 lookups with no resolves: o_ready drops after the fourth. Then a simultaneous push and pop keeps the count at 4.
- Hold i_train_ready=0 for 5 cycles: o_train_valid and o_errPos stay stable and o_resolve_ready=0. Assert rst low mid-request → all outputs return to reset values on the same cycle.
